// File: rtl/mem_arbiter.sv
// mem_arbiter: sole driver of a single-port block RAM, shared by an instruction-fetch port
// and a load/store data port. Alternating arbitration, address range check, one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [15:0]          if_addr,
    output logic                 if_ack,
    output logic [DATA_BITS-1:0] if_rdata,
    output logic                 if_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [15:0]          d_addr,
    input  logic [DATA_BITS-1:0] d_wdata,
    output logic                 d_ack,
    output logic [DATA_BITS-1:0] d_rdata,
    output logic                 d_err,
    output logic                 busy,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_di,
    input  logic [DATA_BITS-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state;
    logic        last_data;  // 1 = the previous grant went to the data port
    logic        sel_data;   // port that owns the access in flight
    logic        grant_data;
    logic [15:0] grant_addr;
    logic        grant_ok;
    logic        grant_we;

    // Under contention the port that lost last time wins; a lone requester always wins.
    always_comb begin
        grant_data = d_req && (!if_req || !last_data);
        grant_addr = grant_data ? d_addr : if_addr;
        grant_ok   = (grant_addr >> ADDR_BITS) == 16'd0;
        grant_we   = grant_data && d_we;
    end

    // NOTE: every register here is assigned with <= so all of them update from the same
    // pre-edge values; a blocking = would let later statements see half-updated state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_data <= 1'b1;
            sel_data  <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_di    <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        sel_data  <= grant_data;
                        last_data <= grant_data;
                        busy      <= 1'b1;
                        if (grant_ok) begin
                            state    <= ISSUE;
                            ram_en   <= 1'b1;
                            ram_we   <= grant_we;
                            ram_addr <= grant_addr[ADDR_BITS-1:0];
                            ram_di   <= d_wdata;
                        end else begin
                            // Out-of-range: answer straight away, RAM stays untouched.
                            state <= RESP;
                            if (grant_data) begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_ack   <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state  <= CAPTURE;
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
                CAPTURE: begin
                    state <= RESP;
                    if (sel_data) begin
                        d_ack   <= 1'b1;
                        d_err   <= 1'b0;
                        d_rdata <= ram_dout;
                    end else begin
                        if_ack   <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= ram_dout;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
